// File: rtl/twiddle_pkg.sv
// twiddle_pkg: shared types and elaboration-time helpers for the twiddle-factor source.
//   quad_e      - quadrant of index k (top two bits of k)
//   seq_state_e - strided sequencer states
//   ONE         - full-scale value at the default 16-bit width; scale_one() for any width
//   cos_q()     - rounded quarter-wave table entry, evaluated at elaboration only
package twiddle_pkg;

  typedef enum logic [1:0] {
    QUAD_0 = 2'd0,
    QUAD_1 = 2'd1,
    QUAD_2 = 2'd2,
    QUAD_3 = 2'd3
  } quad_e;

  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_RUN  = 1'b1
  } seq_state_e;

  localparam int  DEF_DATA_W = 16;
  localparam int  ONE        = (1 << (DEF_DATA_W - 1)) - 1;
  localparam real PI         = 3.14159265358979323846;

  // +1.0 maps to the largest positive code, so -1.0 is its negation and the
  // most negative code never appears.
  function automatic int scale_one(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  // round-half-away-from-zero of cos(2*pi*m/n) * scale_one(w)
  function automatic int cos_q(input int m, input int n, input int w);
    real x;
    x = $cos(2.0 * PI * $itor(m) / $itor(n)) * $itor(scale_one(w));
    if (x >= 0.0) return $rtoi(x + 0.5);
    else          return -$rtoi(0.5 - x);
  endfunction

endpackage

// File: rtl/twiddle_gen_if.sv
// twiddle_gen_if: request/response bundle of the twiddle source.
//   host request : in_valid, in_ready, in_k, in_inv
//   sequencer    : seq_start, seq_base, seq_stride, seq_len, seq_inv, seq_busy
//   result       : out_valid, out_ready, out_re, out_im
//   slave modport = the generator, master modport = the user of the generator.
interface twiddle_gen_if #(
  parameter int N_POINTS = 16,
  parameter int DATA_W   = 16
);
  localparam int LOG2N = $clog2(N_POINTS);

  logic                     in_valid;
  logic                     in_ready;
  logic [LOG2N-1:0]         in_k;
  logic                     in_inv;
  logic                     seq_start;
  logic [LOG2N-1:0]         seq_base;
  logic [LOG2N-1:0]         seq_stride;
  logic [LOG2N:0]           seq_len;
  logic                     seq_inv;
  logic                     seq_busy;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_re;
  logic signed [DATA_W-1:0] out_im;

  modport slave (
    input  in_valid, in_k, in_inv,
    input  seq_start, seq_base, seq_stride, seq_len, seq_inv,
    input  out_ready,
    output in_ready, seq_busy, out_valid, out_re, out_im
  );

  modport master (
    output in_valid, in_k, in_inv,
    output seq_start, seq_base, seq_stride, seq_len, seq_inv,
    output out_ready,
    input  in_ready, seq_busy, out_valid, out_re, out_im
  );

endinterface

// File: rtl/twiddle_quarter_rom.sv
// twiddle_quarter_rom: quarter-wave cosine table C[0..N/4] with two registered
// read ports, so the cosine and its complementary sine come out in the same cycle.
//   clk, rst       - clock, async active-high reset (clears the read registers)
//   en             - load both read registers
//   addr_a, addr_b - table indices (0..N/4)
//   c_a, c_b       - registered C[addr_a], C[addr_b]
module twiddle_quarter_rom
  import twiddle_pkg::*;
#(
  parameter int N_POINTS = 16,
  parameter int DATA_W   = 16,
  localparam int AW      = $clog2(N_POINTS) - 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [AW-1:0]            addr_a,
  input  logic [AW-1:0]            addr_b,
  output logic signed [DATA_W-1:0] c_a,
  output logic signed [DATA_W-1:0] c_b
);

  localparam int DEPTH = 1 << AW;

  // sized to the full address space so every address decodes; entries past
  // N/4 are never addressed and read as zero
  logic signed [DATA_W-1:0] rom_tab [DEPTH];

  for (genvar m = 0; m < DEPTH; m++) begin : g_tab
    if (m <= N_POINTS / 4) begin : g_used
      assign rom_tab[m] = DATA_W'(cos_q(m, N_POINTS, DATA_W));
    end else begin : g_pad
      assign rom_tab[m] = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_a <= '0;
      c_b <= '0;
    end else if (en) begin
      c_a <= rom_tab[addr_a];
      c_b <= rom_tab[addr_b];
    end
  end

endmodule

// File: rtl/twiddle_gen.sv
// twiddle_gen: W_N^k = cos(2*pi*k/N) - j*sin(2*pi*k/N), real and imaginary in
// one beat, optionally conjugated. Two-stage valid/ready pipeline:
//   S1 = quarter-wave ROM read of C[r] and C[N/4-r] plus quadrant/inv
//   S2 = folded, signed result register
// A strided sequencer can own the pipeline input and issue base, base+stride, ...
//   clk, rst - clock, async active-high reset
//   bus      - twiddle_gen_if slave (host request, sequencer control, result)
module twiddle_gen
  import twiddle_pkg::*;
#(
  parameter int N_POINTS = 16,
  parameter int DATA_W   = 16
) (
  input  logic         clk,
  input  logic         rst,
  twiddle_gen_if.slave bus
);

  localparam int LOG2N  = $clog2(N_POINTS);
  localparam int AW     = LOG2N - 1;
  localparam int STAGES = 2;
  localparam logic [AW-1:0]  QUART   = AW'(N_POINTS / 4);
  localparam logic [LOG2N:0] CNT_ONE = (LOG2N + 1)'(1);

  // sequencer
  seq_state_e       state, state_nxt;
  logic [LOG2N-1:0] idx, idx_nxt, stride;
  logic [LOG2N:0]   cnt, cnt_nxt;
  logic             seq_inv_l;
  logic             launch;

  // pipeline input after the request mux
  logic             issue_vld;
  logic [LOG2N-1:0] issue_k;
  logic             issue_inv;

  logic [STAGES:1]  vld_pipe;
  logic             s1_adv, s2_adv;

  quad_e                    s1_q;
  logic                     s1_inv;
  logic signed [DATA_W-1:0] s1_c, s1_s;
  logic signed [DATA_W-1:0] re_f, im_f;
  logic signed [DATA_W-1:0] s2_re, s2_im;

  logic [AW-1:0]            rom_a, rom_b;

  // each stage moves when it is empty or the stage after it moves
  assign s2_adv = !vld_pipe[2] || bus.out_ready;
  assign s1_adv = !vld_pipe[1] || s2_adv;

  assign bus.in_ready  = s1_adv && (state == SEQ_IDLE);
  assign bus.seq_busy  = (state == SEQ_RUN);
  assign bus.out_valid = vld_pipe[2];
  assign bus.out_re    = s2_re;
  assign bus.out_im    = s2_im;

  assign launch = (state == SEQ_IDLE) && bus.seq_start && (bus.seq_len != '0);

  // request mux + sequencer next state; in IDLE the host owns the input, so a
  // host beat in the same cycle as seq_start is accepted before RUN begins
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    issue_vld = bus.in_valid;
    issue_k   = bus.in_k;
    issue_inv = bus.in_inv;
    case (state)
      SEQ_IDLE: begin
        if (launch) begin
          state_nxt = SEQ_RUN;
          idx_nxt   = bus.seq_base;
          cnt_nxt   = bus.seq_len;
        end
      end
      SEQ_RUN: begin
        issue_vld = 1'b1;
        issue_k   = idx;
        issue_inv = seq_inv_l;
        if (s1_adv) begin
          idx_nxt = idx + stride;          // wraps mod N by width
          cnt_nxt = cnt - CNT_ONE;
          if (cnt == CNT_ONE) state_nxt = SEQ_IDLE;
        end
      end
      default: state_nxt = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SEQ_IDLE;
      idx       <= '0;
      cnt       <= '0;
      stride    <= '0;
      seq_inv_l <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
      if (launch) begin
        stride    <= bus.seq_stride;
        seq_inv_l <= bus.seq_inv;
      end
    end
  end

  // r = low bits of k; sine of the in-quadrant angle is C[N/4 - r]
  assign rom_a = {1'b0, issue_k[LOG2N-3:0]};
  assign rom_b = QUART - rom_a;

  twiddle_quarter_rom #(
    .N_POINTS (N_POINTS),
    .DATA_W   (DATA_W)
  ) u_rom (
    .clk    (clk),
    .rst    (rst),
    .en     (s1_adv),
    .addr_a (rom_a),
    .addr_b (rom_b),
    .c_a    (s1_c),
    .c_b    (s1_s)
  );

  // quadrant fold; negation cannot overflow since the table never holds the
  // most negative code
  always_comb begin
    re_f = s1_c;
    im_f = -s1_s;
    case (s1_q)
      QUAD_0: begin re_f =  s1_c; im_f = -s1_s; end
      QUAD_1: begin re_f = -s1_s; im_f = -s1_c; end
      QUAD_2: begin re_f = -s1_c; im_f =  s1_s; end
      QUAD_3: begin re_f =  s1_s; im_f =  s1_c; end
      default: ;
    endcase
    if (s1_inv) im_f = -im_f;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_q     <= QUAD_0;
      s1_inv   <= 1'b0;
      s2_re    <= '0;
      s2_im    <= '0;
    end else begin
      if (s1_adv) begin
        vld_pipe[1] <= issue_vld;
        s1_q        <= quad_e'(issue_k[LOG2N-1 -: 2]);
        s1_inv      <= issue_inv;
      end
      if (s2_adv) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          s2_re <= re_f;
          s2_im <= im_f;
        end
      end
    end
  end

endmodule
